// File: rtl/float_struct_pkg.sv
// Shared float encoding and status codes for the FPU float datapath.
package float_struct;

  localparam int unsigned FP32_BIAS = 127;
  localparam int unsigned INT_W     = 32;
  localparam int unsigned EXP_W     = 8;
  localparam int unsigned MANT_W    = 23;
  localparam int unsigned LZC_W     = 5;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
  } float_point_num;

  typedef enum logic [1:0] {
    OK  = 2'b00,
    NAN = 2'b01,
    INF = 2'b10,
    NUL = 2'b11
  } states;

endpackage

// File: rtl/int_to_float_converter_lzc.sv
// Combinational 32-bit leading-zero counter with all-zero flag.
module leading_zero_counter32
  import float_struct::*;
(
  input  logic [INT_W-1:0] value,
  output logic [LZC_W-1:0] count,
  output logic             zero
);

  // Priority search from the MSB; count is don't-care when value is zero.
  always_comb begin
    logic found;
    count = '0;
    found = 1'b0;
    for (int i = INT_W - 1; i >= 0; i--) begin
      if (!found && value[i]) begin
        count = LZC_W'(INT_W - 1 - i);
        found = 1'b1;
      end
    end
  end

  assign zero = ~|value;

endmodule

// File: rtl/int_to_float_converter.sv
// Pipelined int32/uint32 to IEEE-754 single converter, round-to-nearest-even.
module int_to_float_converter
  import float_struct::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic        is_signed,
  input  logic        arg_vld,
  output logic [31:0] result,
  output logic [1:0]  state,
  output logic        res_vld
);

  // Input capture
  logic             in_vld;
  logic [INT_W-1:0] in_a;
  logic             in_signed;

  // Decode stage
  logic             dec_sign_c;
  logic [INT_W-1:0] dec_mag_c;
  logic             dec_zero_c;
  logic             dec_vld;
  logic             dec_sign;
  logic [INT_W-1:0] dec_mag;
  logic             dec_zero;

  // Normalize stage
  logic [LZC_W-1:0] lzc_count;
  logic             lzc_zero;
  logic             nrm_vld;
  logic             nrm_sign;
  logic             nrm_zero;
  logic [INT_W-1:0] nrm_norm;
  logic [EXP_W-1:0] nrm_exp;

  // Round/pack
  logic [MANT_W-1:0] rnd_mant_c;
  logic              rnd_guard_c;
  logic              rnd_sticky_c;
  logic              rnd_up_c;
  logic [MANT_W:0]   rnd_sum_c;
  logic [EXP_W-1:0]  rnd_exp_c;
  float_point_num    pack_c;

  // Register the operand so the decode logic sees a stable, reset-qualified input.
  always_ff @(posedge clk) begin
    if (!rst) begin
      in_vld    <= 1'b0;
      in_a      <= '0;
      in_signed <= 1'b0;
    end else begin
      in_vld    <= arg_vld;
      in_a      <= a;
      in_signed <= is_signed;
    end
  end

  // Sign/magnitude split; -2^31 negates to 0x8000_0000 which is the correct magnitude.
  always_comb begin
    dec_sign_c = in_signed & in_a[INT_W-1];
    dec_mag_c  = dec_sign_c ? INT_W'(-in_a) : in_a;
    dec_zero_c = (in_a == '0);
  end

  // Decode stage register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      dec_vld  <= 1'b0;
      dec_sign <= 1'b0;
      dec_mag  <= '0;
      dec_zero <= 1'b0;
    end else begin
      dec_vld  <= in_vld;
      dec_sign <= dec_sign_c;
      dec_mag  <= dec_mag_c;
      dec_zero <= dec_zero_c;
    end
  end

  leading_zero_counter32 u_lzc (
    .value (dec_mag),
    .count (lzc_count),
    .zero  (lzc_zero)
  );

  // Normalize so the leading one lands in bit 31; exponent 158 - lzc.
  always_ff @(posedge clk) begin
    if (!rst) begin
      nrm_vld  <= 1'b0;
      nrm_sign <= 1'b0;
      nrm_zero <= 1'b0;
      nrm_norm <= '0;
      nrm_exp  <= '0;
    end else begin
      nrm_vld  <= dec_vld;
      nrm_sign <= dec_sign;
      nrm_zero <= dec_zero | lzc_zero;
      nrm_norm <= dec_mag << lzc_count;
      nrm_exp  <= EXP_W'(FP32_BIAS + INT_W - 1 - 32'(lzc_count));
    end
  end

  // Round-to-nearest-even on the 8 dropped bits; mantissa overflow bumps the exponent.
  always_comb begin
    rnd_mant_c   = nrm_norm[30:8];
    rnd_guard_c  = nrm_norm[7];
    rnd_sticky_c = |nrm_norm[6:0];
    rnd_up_c     = rnd_guard_c & (rnd_sticky_c | rnd_mant_c[0]);
    rnd_sum_c    = (MANT_W+1)'(rnd_mant_c) + (MANT_W+1)'(rnd_up_c);
    rnd_exp_c    = nrm_exp + EXP_W'(rnd_sum_c[MANT_W]);
    pack_c.sign  = nrm_sign;
    pack_c.exp   = rnd_exp_c;
    pack_c.mant  = rnd_sum_c[MANT_W-1:0];
  end

  // Output register; zero always packs as +0 with NUL status.
  always_ff @(posedge clk) begin
    if (!rst) begin
      res_vld <= 1'b0;
      result  <= '0;
      state   <= OK;
    end else begin
      res_vld <= nrm_vld;
      if (nrm_zero) begin
        result <= '0;
        state  <= NUL;
      end else begin
        result <= pack_c;
        state  <= OK;
      end
    end
  end

endmodule

// File: tb/tb_int_to_float_converter.sv
// Self-checking bench for int_to_float_converter: directed table plus randomized stream.
module tb_int_to_float_converter;

  logic        clk;
  logic        rst;
  logic [31:0] a;
  logic        is_signed;
  logic        arg_vld;
  logic [31:0] result;
  logic [1:0]  state;
  logic        res_vld;

  int checks = 0;
  int errors = 0;

  int_to_float_converter dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .is_signed (is_signed),
    .arg_vld   (arg_vld),
    .result    (result),
    .state     (state),
    .res_vld   (res_vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic        sgn;
    logic [31:0] res;
    logic [1:0]  st;
  } vec_t;

  vec_t vecs[11];

  localparam int NCYC = 1204;
  logic        exp_v   [0:NCYC+4];
  logic        exp_rst [0:NCYC+4];
  logic [31:0] exp_r   [0:NCYC+4];
  logic [1:0]  exp_s   [0:NCYC+4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference conversion from the numeric value: {state, result}.
  function automatic logic [33:0] ref_conv(input logic [31:0] x, input logic sgn);
    longint v, q, rem, half;
    int e, sh;
    logic neg;
    v = sgn ? longint'($signed(x)) : longint'({32'b0, x});
    neg = (v < 0);
    if (neg) v = -v;
    if (v == 0) return {2'b11, 32'h0};
    e = 0;
    while ((longint'(1) << (e + 1)) <= v) e++;
    if (e <= 23) begin
      q = v << (23 - e);
    end else begin
      sh   = e - 23;
      q    = v >> sh;
      rem  = v - (q << sh);
      half = longint'(1) << (sh - 1);
      if (rem > half || (rem == half && q[0])) q++;
      if (q == (longint'(1) << 24)) begin
        q = q >> 1;
        e++;
      end
    end
    return {2'b00, neg, 8'(e + 127), q[22:0]};
  endfunction

  // Single conversion in an otherwise idle pipe: exact 3-edge latency check.
  task automatic run_vec(input vec_t v, input int idx);
    @(negedge clk);
    a = v.a; is_signed = v.sgn; arg_vld = 1'b1;
    @(posedge clk);
    @(negedge clk);
    arg_vld = 1'b0; a = $urandom;
    for (int k = 1; k <= 3; k++) begin
      if (k > 1) @(posedge clk); else begin end
      if (k == 1) begin @(posedge clk); end
      #1;
      if (k < 3) check($sformatf("vec%0d early res_vld e+%0d", idx, k), 32'(res_vld), 32'd0);
      else begin
        check($sformatf("vec%0d res_vld", idx), 32'(res_vld), 32'd1);
        check($sformatf("vec%0d result", idx), result, v.res);
        check($sformatf("vec%0d state", idx), 32'(state), 32'(v.st));
      end
    end
    @(posedge clk); #1;
    check($sformatf("vec%0d trailing res_vld", idx), 32'(res_vld), 32'd0);
  endtask

  initial begin
    vecs[0]  = '{32'h0000_0001, 1'b1, 32'h3F80_0000, 2'b00};
    vecs[1]  = '{32'hFFFF_FFFF, 1'b1, 32'hBF80_0000, 2'b00};
    vecs[2]  = '{32'h8000_0000, 1'b1, 32'hCF00_0000, 2'b00};
    vecs[3]  = '{32'h7FFF_FFFF, 1'b1, 32'h4F00_0000, 2'b00};
    vecs[4]  = '{32'd16777217,  1'b1, 32'h4B80_0000, 2'b00};
    vecs[5]  = '{32'd16777219,  1'b1, 32'h4B80_0002, 2'b00};
    vecs[6]  = '{32'd16777218,  1'b0, 32'h4B80_0001, 2'b00};
    vecs[7]  = '{32'hFFFF_FFFF, 1'b0, 32'h4F80_0000, 2'b00};
    vecs[8]  = '{32'h8000_0000, 1'b0, 32'h4F00_0000, 2'b00};
    vecs[9]  = '{32'h0000_0000, 1'b1, 32'h0000_0000, 2'b11};
    vecs[10] = '{32'h0000_0000, 1'b0, 32'h0000_0000, 2'b11};

    // Reset held with a valid input present: outputs stay cleared, input dropped.
    rst = 1'b0; a = 32'd5; is_signed = 1'b1; arg_vld = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      check("reset res_vld", 32'(res_vld), 32'd0);
      check("reset result", result, 32'd0);
      check("reset state", 32'(state), 32'd0);
    end
    @(negedge clk);
    rst = 1'b1; arg_vld = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Pipe is idle here; randomized stream with bubbles and a mid-stream reset.
    for (int c = 0; c < NCYC + 5; c++) begin
      exp_v[c] = 1'b0; exp_rst[c] = 1'b0; exp_r[c] = '0; exp_s[c] = '0;
    end
    for (int c = 0; c < NCYC; c++) begin
      logic [33:0] m;
      int sel;
      @(negedge clk);
      rst = !(c == 600 || c == 601);
      arg_vld = (c < NCYC - 4) && (($urandom % 4) != 0);
      is_signed = 1'($urandom % 2);
      sel = $urandom % 4;
      case (sel)
        0: a = $urandom;
        1: a = $urandom % 16;
        2: a = $urandom >> ($urandom % 32);
        default: begin
          case ($urandom % 4)
            0: a = 32'h8000_0000;
            1: a = 32'h7FFF_FFFF;
            2: a = 32'hFFFF_FFFF;
            default: a = 32'h0100_0001 + ($urandom % 4);
          endcase
        end
      endcase
      @(posedge clk);
      if (!rst) begin
        exp_rst[c] = 1'b1;
        for (int k = c; k <= c + 3; k++) exp_v[k] = 1'b0;
      end else if (arg_vld) begin
        m = ref_conv(a, is_signed);
        exp_v[c+3] = 1'b1;
        exp_r[c+3] = m[31:0];
        exp_s[c+3] = m[33:32];
      end
      #1;
      if (exp_rst[c]) begin
        check("stream reset res_vld", 32'(res_vld), 32'd0);
        check("stream reset result", result, 32'd0);
        check("stream reset state", 32'(state), 32'd0);
      end else begin
        check($sformatf("stream res_vld c%0d", c), 32'(res_vld), 32'(exp_v[c]));
        if (exp_v[c] && res_vld) begin
          check($sformatf("stream result c%0d", c), result, exp_r[c]);
          check($sformatf("stream state c%0d", c), 32'(state), 32'(exp_s[c]));
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/int_to_float_converter.md
# int_to_float_converter

Pipelined converter from 32-bit integer (signed or unsigned) to IEEE-754 single precision, round-to-nearest-even. Acts as the producer side of the FPU float datapath: its `result`/`state`/`res_vld` outputs use the same float encoding and status codes that the floating-point adder consumes. It is fully pipelined: one conversion per clock, fixed latency, no backpressure.

## Interface
- No parameters.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous reset, active-low; sampled on rising edge of `clk`.
- `a`  in  32  integer operand.
- `is_signed`  in  1  1: `a` is two's complement; 0: `a` is unsigned.
- `arg_vld`  in  1  `a`/`is_signed` valid this cycle.
- `result`  out  32  IEEE-754 single {sign, exp[7:0], mant[22:0]}.
- `state`  out  2  status code: OK=2'b00, NAN=2'b01, INF=2'b10, NUL=2'b11.
- `res_vld`  out  1  `result`/`state` valid this cycle.

## Operation
- Stage 1 (decode): sign = `is_signed & a[31]`; mag = sign ? -a : a as 32-bit unsigned (-2^31 gives mag 0x80000000); zero flag = (a == 0).
- Stage 2 (normalize): lzc = leading zeros of mag (0..31; don't-care when zero); norm = mag << lzc, so norm[31] = 1; exp = 127 + 31 - lzc (range 127..158).
- Stage 3 (round/pack): mant = norm[30:8]; guard = norm[7]; sticky = |norm[6:0]; round up iff guard & (sticky | mant[0]).
- Rounding carry out of mant (all ones + 1) → mant = 0, exp = exp + 1 (max 159 = 2^32, still finite).
- Zero input → `result` = 32'h0000_0000 (+0, never -0), `state` = NUL.
- Any other input → `state` = OK. NAN and INF are never produced: int32/uint32 range is finite in float32. No inexact flag.
- Valid bits travel alongside data; data registers may hold stale values when their valid bit is 0, but `result`/`state` must only be interpreted with `res_vld` = 1.

## Timing
- Latency 3: `arg_vld` = 1 sampled at edge N → `res_vld` = 1 and matching `result` after edge N+3.
- Throughput 1/cycle; back-to-back `arg_vld` produces back-to-back `res_vld` in order. Bubbles propagate unchanged.
- Reset (`rst` = 0 at an edge): all valid bits → 0, `result` → 0, `state` → OK (2'b00), `res_vld` → 0. In-flight operations are discarded, not completed.
- First `arg_vld` accepted on the first edge with `rst` = 1; its result appears 3 edges later.
- `arg_vld` together with `rst` = 0 at the same edge: reset wins, input dropped.
- Outputs are registered; no combinational path from inputs to outputs.

## Structure
- Shared package `float_struct`: `float_point_num` struct (sign, exp[7:0], mant[22:0]), `states` enum (OK/NAN/INF/NUL), and constant `FP32_BIAS` = 127. The `states` enum lives in the package, not at file scope.
- Sub-module `leading_zero_counter32`: combinational, 32-bit in, 5-bit count out plus all-zero flag; instantiated in stage 2.
- Top-level module holds the three pipeline register stages and the round/pack logic.

## Test plan
- Reset/latency: hold `rst` = 0 for 2 cycles, then signed 1 → `res_vld` exactly 3 cycles later, `result` = 0x3F80_0000, `state` = OK; outputs 0/OK/0 during reset.
- Sign and extremes: signed -1 → 0xBF80_0000; signed 0x8000_0000 → 0xCF00_0000; signed 0x7FFF_FFFF → 0x4F00_0000 (rounded up).
- Ties to even: 16777217 → 0x4B80_0000; 16777219 → 0x4B80_0002; 16777218 → 0x4B80_0001.
- Unsigned mode: 0xFFFF_FFFF with `is_signed` = 0 → 0x4F80_0000 (mantissa carry bumps exp to 159); 0x8000_0000 → 0x4F00_0000.
- Zero: 0 (both modes) → 0x0000_0000, `state` = NUL.
- Streaming: 1000 random back-to-back inputs with random bubbles, plus `rst` pulsed mid-stream → results match a software reference in order; everything in flight at the reset is dropped with no `res_vld`.
